// File: rtl/add_round_key.sv
// AES round-key addition stage: XORs each state beat with the key for the
// current round, tracks the round index itself, one valid/ready register stage.
module add_round_key #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_we,
  input  logic [3:0]   key_waddr,
  input  logic [0:127] key_wdata,
  input  logic         round_clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic [3:0]   out_round,
  output logic         out_last
);

  // Handshake: a beat moves on any rising edge where valid && ready; in_ready
  // is !out_valid || out_ready and never looks at in_valid.

  localparam logic [3:0] LAST = 4'(NR);

  logic [0:127] r_key [0:NR];
  logic [3:0]   r_cnt;
  logic         r_out_valid;
  logic [0:127] r_out_data;
  logic [3:0]   r_out_round;
  logic         r_out_last;

  logic         w_accept;
  logic [3:0]   w_cnt_eff;
  logic [3:0]   w_cnt_next;
  logic [0:127] w_key;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_eff  = round_clr ? 4'd0 : r_cnt;
  assign w_cnt_next = (w_cnt_eff == LAST) ? 4'd0 : w_cnt_eff + 4'd1;

  // Table read mux; entries beyond NR do not exist so an unmatched index reads 0.
  always_comb begin
    w_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (w_cnt_eff == i[3:0]) w_key = r_key[i];
    end
  end

  // Key table: the read above sees pre-edge contents even on a same-edge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= NR; i++) r_key[i] <= '0;
    end else if (key_we) begin
      for (int i = 0; i <= NR; i++) begin
        if (key_waddr == i[3:0]) r_key[i] <= key_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_next;
    end else if (round_clr) begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_round <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data ^ w_key;
      r_out_round <= w_cnt_eff;
      r_out_last  <= (w_cnt_eff == LAST);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_round = r_out_round;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key: FIPS-197 vectors, round wrap, backpressure,
// same-edge key write, async reset; a negedge scoreboard tracks every beat.
module tb_add_round_key;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_we;
  logic [3:0]   key_waddr;
  logic [0:127] key_wdata;
  logic         round_clr;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;
  logic [3:0]   out_round;
  logic         out_last;

  int checks   = 0;
  int failures = 0;

  logic [159:0] exp_q[$];
  logic [127:0] m_key [16];
  logic [3:0]   m_cnt;

  add_round_key #(.NR(NR)) dut (
    .clk(clk), .rst(rst),
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .round_clr(round_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_round(out_round), .out_last(out_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key_wr(input logic [3:0] a, input logic [127:0] d);
    key_we = 1'b1; key_waddr = a; key_wdata = d;
    step();
    key_we = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [127:0] d, input logic [3:0] r, input logic l);
    chk({tag, "_valid"}, 160'(out_valid), 160'(1'b1));
    chk({tag, "_data"},  160'(out_data),  160'(d));
    chk({tag, "_round"}, 160'(out_round), 160'(r));
    chk({tag, "_last"},  160'(out_last),  160'(l));
  endtask

  // scoreboard: at negedge, inputs/outputs are settled for the coming edge
  always @(negedge clk) begin
    logic [3:0] eff;
    if (!rst) begin
      exp_q.delete();
      m_cnt = '0;
      for (int i = 0; i < 16; i++) m_key[i] = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_beat", 160'(1), 160'(0));
        else chk("sb_beat", {27'd0, out_last, out_round, out_data}, exp_q.pop_front());
      end
      eff = round_clr ? 4'd0 : m_cnt;
      if (in_valid && in_ready) begin
        exp_q.push_back({27'd0, (eff == 4'(NR)), eff, 128'(in_data) ^ m_key[eff]});
        m_cnt = (eff == 4'(NR)) ? 4'd0 : eff + 4'd1;
      end else if (round_clr) begin
        m_cnt = '0;
      end
      if (key_we && key_waddr <= 4'(NR)) m_key[key_waddr] = key_wdata;
    end
  end

  initial begin
    rst = 1'b0; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    round_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_out_data",  160'(out_data),  160'(0));
    chk("rst_out_round", 160'(out_round), 160'(0));
    chk("rst_out_last",  160'(out_last),  160'(0));
    chk("rst_in_ready",  160'(in_ready),  160'(1));
    step();
    rst = 1'b1;

    // FIPS-197 round 0 and round 1
    key_wr(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    key_wr(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    round_clr = 1'b1; in_valid = 1'b1; in_data = 128'h3243f6a8885a308d313198a2e0370734;
    step();
    round_clr = 1'b0;
    chk_out("fips_r0", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0);
    in_data = 128'h046681e5e0cb199a48f8d37a2806264c;
    step();
    chk_out("fips_r1", 128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("drain_valid", 160'(out_valid), 160'(0));

    // wrap: keys {16{i}}, 12 zero beats back to back
    for (int i = 0; i <= NR; i++) key_wr(4'(i), rep(8'(i)));
    round_clr = 1'b1;
    step();
    round_clr = 1'b0;
    in_valid = 1'b1; in_data = '0;
    for (int b = 0; b < 12; b++) begin
      chk("wrap_in_ready", 160'(in_ready), 160'(1));
      step();
      chk_out("wrap", rep(8'((b == 11) ? 0 : b)), 4'((b == 11) ? 0 : b), (b == 10));
    end
    in_valid = 1'b0;
    step();

    // backpressure: round counter is at 1
    in_valid = 1'b1; in_data = rep(8'h11);
    step();
    chk_out("bp_a", rep(8'h10), 4'd1, 1'b0);
    out_ready = 1'b0; in_data = rep(8'h22);
    #1;
    chk("bp_in_ready_low", 160'(in_ready), 160'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("bp_hold", rep(8'h10), 4'd1, 1'b0);
      chk("bp_hold_in_ready", 160'(in_ready), 160'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 160'(in_ready), 160'(1));
    step();
    chk_out("bp_b", rep(8'h20), 4'd2, 1'b0);
    in_data = rep(8'h33);
    step();
    chk_out("bp_c", rep(8'h30), 4'd3, 1'b0);
    in_valid = 1'b0;
    step();
    chk("bp_drain", 160'(out_valid), 160'(0));

    // same-edge key write with round_clr and accept
    key_wr(4'd0, rep(8'h5a));
    key_we = 1'b1; key_waddr = 4'd0; key_wdata = '1;
    round_clr = 1'b1; in_valid = 1'b1; in_data = '0;
    step();
    key_we = 1'b0; round_clr = 1'b0;
    chk_out("same_edge_old", rep(8'h5a), 4'd0, 1'b0);
    step();
    chk_out("same_edge_cnt1", rep(8'h01), 4'd1, 1'b0);
    round_clr = 1'b1;
    step();
    round_clr = 1'b0;
    chk_out("same_edge_new", '1, 4'd0, 1'b0);
    in_valid = 1'b0;
    step();

    // async reset while a beat is stalled (counter at 1)
    out_ready = 1'b0; in_valid = 1'b1; in_data = rep(8'h77);
    step();
    in_valid = 1'b0;
    chk_out("stall_pre_rst", rep(8'h76), 4'd1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 160'(out_valid), 160'(0));
    chk("arst_out_data",  160'(out_data),  160'(0));
    chk("arst_out_round", 160'(out_round), 160'(0));
    chk("arst_out_last",  160'(out_last),  160'(0));
    chk("arst_in_ready",  160'(in_ready),  160'(1));
    step();
    rst = 1'b1; out_ready = 1'b1;
    key_wr(4'd15, '1);
    // every table entry must read back as zero
    for (int r = 0; r <= NR; r++) begin
      round_clr = (r == 0); in_valid = 1'b1; in_data = rep(8'(8'h40 + r));
      step();
      chk_out("post_rst_key_zero", rep(8'(8'h40 + r)), 4'(r), (r == NR));
    end
    round_clr = 1'b0; in_valid = 1'b0;
    step();
    step();
    chk("sb_all_drained", 160'(exp_q.size()), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
